// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the multi-port RAM write scheduler.
// Holds the controller state encoding and the number of RAM write ports.
package ram_ctrl_pkg;

  localparam int NWRPORT = 4;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/wr_grant_select.sv
// Round-robin scan of write requesters that grants up to NWRPORT of them per cycle.
// Requesters whose address matches one already granted this cycle are skipped.
module wr_grant_select
  import ram_ctrl_pkg::*;
#(
  parameter int NREQ  = 6,
  parameter int INDEX = 4,
  parameter int PW    = 3
) (
  input  logic [NREQ-1:0]        valid,
  input  logic [NREQ*INDEX-1:0]  addr,
  input  logic [PW-1:0]          rr_ptr,
  output logic [NREQ-1:0]        grant,
  output logic [NWRPORT*PW-1:0]  port_idx,
  output logic [2:0]             count
);

  // Walk requesters from rr_ptr, assigning each clean grant to the next free port
  always_comb begin
    int   r;
    logic conflict;
    grant    = '0;
    port_idx = '0;
    count    = 3'd0;
    r        = 0;
    conflict = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      r = int'(rr_ptr) + i;
      if (r >= NREQ) begin
        r = r - NREQ;
      end else begin
        r = r;
      end
      conflict = 1'b0;
      for (int j = 0; j < NWRPORT; j++) begin
        if ((j < int'(count)) &&
            (addr[int'(port_idx[j*PW +: PW])*INDEX +: INDEX] == addr[r*INDEX +: INDEX])) begin
          conflict = 1'b1;
        end else begin
          conflict = conflict;
        end
      end
      if (valid[r] && (count < 3'd4) && !conflict) begin
        grant[r]                              = 1'b1;
        port_idx[int'(count[1:0])*PW +: PW]   = PW'(r);
        count                                 = count + 3'd1;
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/ram_wr_sched.sv
// Write scheduler for a 4-write-port RAM: clears the RAM after reset or on request,
// then arbitrates requesters round-robin onto the write ports with registered outputs.
module ram_wr_sched
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int INDEX = 4,
  parameter int WIDTH = 8,
  parameter int NREQ  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*INDEX-1:0]   req_addr_i,
  input  logic [NREQ*WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    init_start_i,
  output logic                    we0_o,
  output logic                    we1_o,
  output logic                    we2_o,
  output logic                    we3_o,
  output logic [INDEX-1:0]        addr0wr_o,
  output logic [INDEX-1:0]        addr1wr_o,
  output logic [INDEX-1:0]        addr2wr_o,
  output logic [INDEX-1:0]        addr3wr_o,
  output logic [WIDTH-1:0]        data0wr_o,
  output logic [WIDTH-1:0]        data1wr_o,
  output logic [WIDTH-1:0]        data2wr_o,
  output logic [WIDTH-1:0]        data3wr_o,
  output logic                    init_done_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW = (INDEX > 2) ? INDEX - 2 : 1;
  localparam logic [KW-1:0] KMAX = KW'(DEPTH / 4 - 1);

  state_e                 state;
  logic [KW-1:0]          sweep_k;
  logic [PW-1:0]          rr_ptr;
  logic [NWRPORT-1:0]     we;
  logic [INDEX-1:0]       waddr [NWRPORT];
  logic [WIDTH-1:0]       wdata [NWRPORT];

  logic                   run_ok;
  logic [NREQ-1:0]        grant;
  logic [NWRPORT*PW-1:0]  port_idx;
  logic [2:0]             count;
  logic [PW-1:0]          last_idx;
  logic [PW-1:0]          rr_next;

  // A re-clear request or reset suppresses all grants in the same cycle
  assign run_ok = (state == RUN) && !init_start_i && !reset;

  wr_grant_select #(
    .NREQ  (NREQ),
    .INDEX (INDEX),
    .PW    (PW)
  ) u_grant (
    .valid    (req_valid_i & {NREQ{run_ok}}),
    .addr     (req_addr_i),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_idx (port_idx),
    .count    (count)
  );

  assign req_ready_o = grant;
  assign init_done_o = (state == RUN);

  // Next round-robin start is one past the last requester granted this cycle
  always_comb begin
    last_idx = '0;
    if (count != 3'd0) begin
      last_idx = port_idx[(int'(count) - 1)*PW +: PW];
    end else begin
      last_idx = '0;
    end
    if (last_idx == PW'(NREQ - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = last_idx + PW'(1);
    end
  end

  // Controller state, sweep counter, round-robin pointer and registered write ports
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      sweep_k <= '0;
      rr_ptr  <= '0;
      for (int p = 0; p < NWRPORT; p++) begin
        we[p]    <= 1'b0;
        waddr[p] <= '0;
        wdata[p] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          for (int p = 0; p < NWRPORT; p++) begin
            we[p]    <= 1'b1;
            waddr[p] <= (INDEX'(sweep_k) << 2) | INDEX'(p);
            wdata[p] <= '0;
          end
          if (sweep_k == KMAX) begin
            state   <= RUN;
            sweep_k <= '0;
          end else begin
            sweep_k <= sweep_k + KW'(1);
          end
        end
        RUN: begin
          if (init_start_i) begin
            state   <= INIT;
            sweep_k <= '0;
            for (int p = 0; p < NWRPORT; p++) begin
              we[p]    <= 1'b0;
              waddr[p] <= '0;
              wdata[p] <= '0;
            end
          end else begin
            for (int p = 0; p < NWRPORT; p++) begin
              if (p < int'(count)) begin
                we[p]    <= 1'b1;
                waddr[p] <= req_addr_i[int'(port_idx[p*PW +: PW])*INDEX +: INDEX];
                wdata[p] <= req_data_i[int'(port_idx[p*PW +: PW])*WIDTH +: WIDTH];
              end else begin
                we[p]    <= 1'b0;
                waddr[p] <= '0;
                wdata[p] <= '0;
              end
            end
            if (count != 3'd0) begin
              rr_ptr <= rr_next;
            end else begin
              rr_ptr <= rr_ptr;
            end
          end
        end
        default: begin
          state   <= INIT;
          sweep_k <= '0;
        end
      endcase
    end
  end

  assign we0_o     = we[0];
  assign we1_o     = we[1];
  assign we2_o     = we[2];
  assign we3_o     = we[3];
  assign addr0wr_o = waddr[0];
  assign addr1wr_o = waddr[1];
  assign addr2wr_o = waddr[2];
  assign addr3wr_o = waddr[3];
  assign data0wr_o = wdata[0];
  assign data1wr_o = wdata[1];
  assign data2wr_o = wdata[2];
  assign data3wr_o = wdata[3];

endmodule

// File: tb/tb_ram_wr_sched.sv
// Directed bench for ram_wr_sched: clear sweep, round-robin arbitration, address
// conflicts, write latency into a behavioural RAM, re-clear requests and mid-sweep reset.
module tb_ram_wr_sched;

  logic        clk;
  logic        reset;
  logic [5:0]  req_valid;
  logic [23:0] req_addr;
  logic [47:0] req_data;
  logic [5:0]  req_ready;
  logic        init_start;
  logic        we0, we1, we2, we3;
  logic [3:0]  addr0, addr1, addr2, addr3;
  logic [7:0]  data0, data1, data2, data3;
  logic        init_done;

  logic [7:0]  mem [16];
  int          tests;
  int          fails;

  ram_wr_sched #(.DEPTH(16), .INDEX(4), .WIDTH(8), .NREQ(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .init_start_i (init_start),
    .we0_o        (we0),
    .we1_o        (we1),
    .we2_o        (we2),
    .we3_o        (we3),
    .addr0wr_o    (addr0),
    .addr1wr_o    (addr1),
    .addr2wr_o    (addr2),
    .addr3wr_o    (addr3),
    .data0wr_o    (data0),
    .data1wr_o    (data1),
    .data2wr_o    (data2),
    .data3wr_o    (data3),
    .init_done_o  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-write-port RAM fed by the scheduler outputs
  always @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
    if (we2) mem[addr2] <= data2;
    if (we3) mem[addr3] <= data3;
  end

  task automatic set_req(input int r, input logic v, input logic [3:0] a, input logic [7:0] d);
    req_valid[r]        = v;
    req_addr[r*4 +: 4]  = a;
    req_data[r*8 +: 8]  = d;
  endtask

  task automatic reset_and_sweep();
    req_valid  = 6'b000000;
    init_start = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    init_start = 1'b0;
    req_valid  = 6'b111111;
    req_addr   = '0;
    req_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({we3, we2, we1, we0} !== 4'b0000 || {addr3, addr2, addr1, addr0} !== 16'h0000 ||
        {data3, data2, data1, data0} !== 32'h0) begin
      fails++;
      $display("FAIL reset_ports we=%b addr=%h data=%h expected all zero",
               {we3, we2, we1, we0}, {addr3, addr2, addr1, addr0}, {data3, data2, data1, data0});
    end
    tests++;
    if (req_ready !== 6'b000000 || init_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready ready=%b done=%b expected 000000 0", req_ready, init_done);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] exp_addr;
    for (int k = 0; k < 16; k++) mem[k] = 8'hFF;
    req_valid = 6'b111111;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_addr = {4'(4*k + 3), 4'(4*k + 2), 4'(4*k + 1), 4'(4*k)};
      tests++;
      if ({we3, we2, we1, we0} !== 4'b1111 || {addr3, addr2, addr1, addr0} !== exp_addr ||
          {data3, data2, data1, data0} !== 32'h0) begin
        fails++;
        $display("FAIL sweep_k%0d we=%b addr=%h data=%h expected 1111 %h 0", k,
                 {we3, we2, we1, we0}, {addr3, addr2, addr1, addr0}, {data3, data2, data1, data0}, exp_addr);
      end
      tests++;
      if (init_done !== (k == 3)) begin
        fails++;
        $display("FAIL sweep_done_k%0d done=%b expected %b", k, init_done, (k == 3));
      end
      if (k < 3) begin
        tests++;
        if (req_ready !== 6'b000000) begin
          fails++;
          $display("FAIL sweep_ready_k%0d ready=%b expected 000000", k, req_ready);
        end
      end
      if (k == 2) req_valid = 6'b000000;
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (mem[k] !== 8'h00) begin
        fails++;
        $display("FAIL sweep_mem[%0d] got %h expected 00", k, mem[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    reset_and_sweep();
    for (int r = 0; r < 6; r++) set_req(r, 1'b1, 4'(r + 1), 8'(8'h10 + r));
    #1;
    tests++;
    if (req_ready !== 6'b001111) begin
      fails++;
      $display("FAIL rr_ready0 ready=%b expected 001111", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({we3, we2, we1, we0} !== 4'b1111 || {addr3, addr2, addr1, addr0} !== 16'h4321 ||
        {data3, data2, data1, data0} !== 32'h13121110) begin
      fails++;
      $display("FAIL rr_ports0 we=%b addr=%h data=%h expected 1111 4321 13121110",
               {we3, we2, we1, we0}, {addr3, addr2, addr1, addr0}, {data3, data2, data1, data0});
    end
    tests++;
    if (req_ready !== 6'b110011) begin
      fails++;
      $display("FAIL rr_ready1 ready=%b expected 110011", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 6'b000000;
    tests++;
    if ({addr3, addr2, addr1, addr0} !== 16'h2165 || {data3, data2, data1, data0} !== 32'h11101514) begin
      fails++;
      $display("FAIL rr_ports1 addr=%h data=%h expected 2165 11101514",
               {addr3, addr2, addr1, addr0}, {data3, data2, data1, data0});
    end
  endtask

  task automatic test_conflict();
    reset_and_sweep();
    req_valid = 6'b000000;
    set_req(0, 1'b1, 4'd5, 8'hA1);
    set_req(2, 1'b1, 4'd5, 8'hB2);
    #1;
    tests++;
    if (req_ready !== 6'b000001) begin
      fails++;
      $display("FAIL conflict_ready0 ready=%b expected 000001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 4'd5, 8'hA1);
    #1;
    tests++;
    if (req_ready !== 6'b000100) begin
      fails++;
      $display("FAIL conflict_ready1 ready=%b expected 000100", req_ready);
    end
    tests++;
    if ({we3, we2, we1, we0} !== 4'b0001 || addr0 !== 4'd5 || data0 !== 8'hA1 ||
        {addr3, addr2, addr1} !== 12'h000 || {data3, data2, data1} !== 24'h0) begin
      fails++;
      $display("FAIL conflict_port_a we=%b addr=%h data=%h expected 0001 0005 000000a1",
               {we3, we2, we1, we0}, {addr3, addr2, addr1, addr0}, {data3, data2, data1, data0});
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 6'b000000;
    tests++;
    if (we0 !== 1'b1 || addr0 !== 4'd5 || data0 !== 8'hB2) begin
      fails++;
      $display("FAIL conflict_port_b we0=%b addr0=%h data0=%h expected 1 5 b2", we0, addr0, data0);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (mem[5] !== 8'hB2) begin
      fails++;
      $display("FAIL conflict_mem5 got %h expected b2", mem[5]);
    end
  endtask

  task automatic test_latency();
    req_valid = 6'b000000;
    set_req(0, 1'b1, 4'd9, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    req_valid = 6'b000000;
    tests++;
    if (we0 !== 1'b1 || addr0 !== 4'd9 || data0 !== 8'h3C) begin
      fails++;
      $display("FAIL latency_port we0=%b addr0=%h data0=%h expected 1 9 3c", we0, addr0, data0);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (mem[9] !== 8'h3C || we0 !== 1'b0 || addr0 !== 4'd0 || data0 !== 8'h00) begin
      fails++;
      $display("FAIL latency_read mem9=%h we0=%b addr0=%h data0=%h expected 3c 0 0 00",
               mem[9], we0, addr0, data0);
    end
  endtask

  task automatic test_init_start();
    for (int r = 0; r < 6; r++) set_req(r, 1'b1, 4'(r + 1), 8'(8'h20 + r));
    init_start = 1'b1;
    #1;
    tests++;
    if (req_ready !== 6'b000000) begin
      fails++;
      $display("FAIL init_start_ready ready=%b expected 000000", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    init_start = 1'b0;
    tests++;
    if (we0 !== 1'b0 || init_done !== 1'b0 || req_ready !== 6'b000000) begin
      fails++;
      $display("FAIL init_start_enter we0=%b done=%b ready=%b expected 0 0 000000",
               we0, init_done, req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (we0 !== 1'b1 || addr0 !== 4'(4*k) || init_done !== (k == 3)) begin
        fails++;
        $display("FAIL init_start_sweep_k%0d we0=%b addr0=%h done=%b expected 1 %h %b",
                 k, we0, addr0, init_done, 4'(4*k), (k == 3));
      end
    end
    tests++;
    if (req_ready !== 6'b011110) begin
      fails++;
      $display("FAIL init_start_resume ready=%b expected 011110", req_ready);
    end
    req_valid = 6'b000000;
  endtask

  task automatic test_reset_mid_sweep();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({addr3, addr2, addr1, addr0} !== 16'h7654) begin
      fails++;
      $display("FAIL midreset_pre addr=%h expected 7654", {addr3, addr2, addr1, addr0});
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({we3, we2, we1, we0} !== 4'b0000 || {addr3, addr2, addr1, addr0} !== 16'h0000 ||
        {data3, data2, data1, data0} !== 32'h0 || init_done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_zero we=%b addr=%h data=%h done=%b expected all zero",
               {we3, we2, we1, we0}, {addr3, addr2, addr1, addr0}, {data3, data2, data1, data0}, init_done);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({we3, we2, we1, we0} !== 4'b1111 || {addr3, addr2, addr1, addr0} !== 16'h3210) begin
      fails++;
      $display("FAIL midreset_restart we=%b addr=%h expected 1111 3210",
               {we3, we2, we1, we0}, {addr3, addr2, addr1, addr0});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    init_start = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    test_reset();
    test_sweep();
    test_round_robin();
    test_conflict();
    test_latency();
    test_init_start();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
